// File: rtl/fifo_pkg.sv
// Shared definitions for the multi-port FIFO: default geometry, lane-count width and a clog2 helper.
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int W_DEF = 6;
  localparam int N_DEF = 4;
  localparam int K_DEF = 2;
  localparam int CNT_W = clog2(K_DEF + 1);

  typedef logic [CNT_W-1:0] lane_cnt_t;

endpackage

// File: rtl/fifo_ram_mw.sv
// D x W register array, K write lanes at wbase+i, K combinational read lanes at rbase+i (mod D).
// Writes land on the rising edge; reads see them the following cycle. No reset on storage.
module fifo_ram_mw
  import fifo_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic           clk,
  input  logic [K-1:0]   we_i,
  input  logic [N-1:0]   wbase_i,
  input  logic [K*W-1:0] wdata_i,
  input  logic [N-1:0]   rbase_i,
  output logic [K*W-1:0] rdata_o
);

  localparam int D = 1 << N;

  logic [W-1:0] mem_q [D];

  // Lane addresses wrap naturally in N bits, so a window crossing D-1 continues at 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++) begin
      if (we_i[i]) mem_q[wbase_i + N'(i)] <= wdata_i[i*W +: W];
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < K; i++) begin
      rdata_o[i*W +: W] = mem_q[rbase_i + N'(i)];
    end
  end

endmodule

// File: rtl/fifo_multiport.sv
// Circular FIFO pushing/popping up to K entries per clock with all-or-nothing admission.
// Head visible combinationally; push-to-head latency 1 cycle; rejected requests pulse wr_err/rd_err.
module fifo_multiport
  import fifo_pkg::*;
#(
  parameter int w = W_DEF,
  parameter int n = N_DEF,
  parameter int K = K_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [$clog2(K+1)-1:0] wr_cnt,
  input  logic [K*w-1:0]         data_in,
  input  logic [$clog2(K+1)-1:0] rd_cnt,
  output logic [K*w-1:0]         data_out,
  output logic [K-1:0]           valid_out,
  output logic [n:0]             count,
  output logic [n:0]             free,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   wr_err,
  output logic                   rd_err
);

  localparam int         D     = 1 << n;
  localparam int         CNT_W = clog2(K + 1);
  localparam logic [n:0] DEPTH = (n+1)'(D);
  localparam logic [n:0] LANES = (n+1)'(K);

  logic [n-1:0] r_addr_q, r_addr_d;
  logic [n-1:0] w_addr_q, w_addr_d;
  logic [n:0]   count_q, count_d;
  logic         wr_err_q, wr_err_d;
  logic         rd_err_q, rd_err_d;

  logic [n:0]   wr_num, rd_num;
  logic         wr_req, rd_req;
  logic         wr_ok, rd_ok;
  logic [K-1:0] we;

  assign wr_num = (n+1)'(wr_cnt);
  assign rd_num = (n+1)'(rd_cnt);
  assign wr_req = (wr_cnt != CNT_W'(0));
  assign rd_req = (rd_cnt != CNT_W'(0));

  // Both sides judged on the registered state, so a read cannot free room for a same-cycle write.
  assign wr_ok = !flush && wr_req && (wr_num <= LANES) && (wr_num <= free);
  assign rd_ok = !flush && rd_req && (rd_num <= LANES) && (rd_num <= count_q);

  always_comb begin
    we = '0;
    for (int i = 0; i < K; i++) begin
      we[i] = wr_ok && ((n+1)'(i) < wr_num);
    end
  end

  always_comb begin
    r_addr_d = r_addr_q;
    w_addr_d = w_addr_q;
    count_d  = count_q;
    wr_err_d = 1'b0;
    rd_err_d = 1'b0;
    if (flush) begin
      r_addr_d = '0;
      w_addr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) w_addr_d = w_addr_q + n'(wr_cnt);
      if (rd_ok) r_addr_d = r_addr_q + n'(rd_cnt);
      count_d  = count_q + (wr_ok ? wr_num : '0) - (rd_ok ? rd_num : '0);
      wr_err_d = wr_req && !wr_ok;
      rd_err_d = rd_req && !rd_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_q <= '0;
      w_addr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      r_addr_q <= r_addr_d;
      w_addr_q <= w_addr_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  fifo_ram_mw #(
    .W (w),
    .N (n),
    .K (K)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .wbase_i (w_addr_q),
    .wdata_i (data_in),
    .rbase_i (r_addr_q),
    .rdata_o (data_out)
  );

  always_comb begin
    valid_out = '0;
    for (int i = 0; i < K; i++) begin
      valid_out[i] = (count_q > (n+1)'(i));
    end
  end

  assign count       = count_q;
  assign free        = DEPTH - count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH);
  assign almost_full = (free < LANES);
  assign wr_err      = wr_err_q;
  assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_fifo_multiport.sv
// Scoreboarded bench: a queue-based reference model predicts each cycle's outcome, a negedge monitor compares.
module tb_fifo_multiport;
  import fifo_pkg::*;

  localparam int W  = 6;
  localparam int N  = 4;
  localparam int K  = 2;
  localparam int D  = 16;
  localparam int CW = $clog2(K+1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic [CW-1:0]  wr_cnt = '0;
  logic [CW-1:0]  rd_cnt = '0;
  logic [K*W-1:0] data_in = '0;
  logic [K*W-1:0] data_out;
  logic [K-1:0]   valid_out;
  logic [N:0]     count, free;
  logic           empty, full, almost_full, wr_err, rd_err;

  fifo_multiport #(.w(W), .n(N), .K(K)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_cnt      (wr_cnt),
    .data_in     (data_in),
    .rd_cnt      (rd_cnt),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .count       (count),
    .free        (free),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .wr_err      (wr_err),
    .rd_err      (rd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int             at;
    int             cnt;
    bit             werr;
    bit             rerr;
    logic [K*W-1:0] lanes;
  } exp_t;

  logic [W-1:0] mq[$];
  exp_t         eq[$];
  exp_t         me;
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the reference model, queue the expected outcome.
  task automatic step(input int wc, input int rc, input bit fl, input logic [K*W-1:0] din);
    int   sz;
    bit   wok, rok;
    exp_t e;
    wr_cnt  = CW'(wc);
    rd_cnt  = CW'(rc);
    flush   = fl;
    data_in = din;
    sz  = mq.size();
    wok = (wc != 0) && (wc <= K) && (wc <= D - sz);
    rok = (rc != 0) && (rc <= K) && (rc <= sz);
    e.at = cyc + 1;
    if (fl) begin
      mq.delete();
      e.werr = 1'b0;
      e.rerr = 1'b0;
    end else begin
      if (rok) repeat (rc) void'(mq.pop_front());
      if (wok) for (int i = 0; i < wc; i++) mq.push_back(din[i*W +: W]);
      e.werr = (wc != 0) && !wok;
      e.rerr = (rc != 0) && !rok;
    end
    e.cnt   = mq.size();
    e.lanes = '0;
    for (int i = 0; i < K; i++) if (i < mq.size()) e.lanes[i*W +: W] = mq[i];
    eq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_valid"}, 32'(valid_out), 0);
    chk({tag, "_free"}, 32'(free), D);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_werr"}, 32'(wr_err), 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset();
    wr_cnt = '0;
    rd_cnt = '0;
    flush  = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    mq.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (eq.size() > 0 && eq[0].at == cyc) begin
      me = eq.pop_front();
      chk("count", 32'(count), 32'(me.cnt));
      chk("free", 32'(free), 32'(D - me.cnt));
      chk("empty", 32'(empty), 32'(me.cnt == 0));
      chk("full", 32'(full), 32'(me.cnt == D));
      chk("almost_full", 32'(almost_full), 32'((D - me.cnt) < K));
      chk("wr_err", 32'(wr_err), 32'(me.werr));
      chk("rd_err", 32'(rd_err), 32'(me.rerr));
      for (int i = 0; i < K; i++) begin
        chk("valid_out", 32'(valid_out[i]), 32'(me.cnt > i));
        if (me.cnt > i) chk("data_lane", 32'(data_out[i*W +: W]), 32'(me.lanes[i*W +: W]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [K*W-1:0] pair(input logic [W-1:0] a, input logic [W-1:0] b);
    return {b, a};
  endfunction

  initial begin
    #3;
    chk_reset_state("init_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill five entries, then reset asynchronously mid-operation.
    step(2, 0, 0, pair(6'd9, 6'd10));
    step(2, 0, 0, pair(6'd11, 6'd12));
    step(1, 0, 0, pair(6'd13, 6'd0));
    mid_reset();

    // Dual push then dual pop: ordering and count 6->4->2->0.
    step(2, 0, 0, pair(6'd1, 6'd2));
    step(2, 0, 0, pair(6'd3, 6'd4));
    step(2, 0, 0, pair(6'd5, 6'd6));
    repeat (3) step(0, 2, 0, '0);

    // Fill to 15, reject an oversize push, top off to full, then read+write while full.
    for (int i = 0; i < 7; i++) step(2, 0, 0, pair(6'(2*i + 20), 6'(2*i + 21)));
    step(1, 0, 0, pair(6'd40, 6'd0));
    step(2, 0, 0, pair(6'd41, 6'd42));
    step(1, 0, 0, pair(6'd43, 6'd0));
    step(1, 1, 0, pair(6'd44, 6'd0));
    step(3, 0, 0, pair(6'd45, 6'd46));

    // Wrap-around: put both pointers at 15, push a pair that straddles slot 15 and slot 0.
    mid_reset();
    for (int i = 0; i < 15; i++) step(1, 0, 0, pair(6'(i), 6'd0));
    for (int i = 0; i < 7; i++) step(0, 2, 0, '0);
    step(0, 1, 0, '0);
    step(2, 0, 0, pair(6'h2A, 6'h15));
    step(0, 2, 0, '0);

    // Underflow at count 1, then flush beating a same-cycle write.
    step(1, 0, 0, pair(6'd33, 6'd0));
    step(0, 2, 0, '0);
    step(0, 3, 0, '0);
    step(2, 0, 1, pair(6'd50, 6'd51));
    step(0, 0, 0, '0);
    step(0, 1, 0, '0);

    // Randomized traffic including illegal counts and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0),
           (K*W)'($urandom));
    end

    step(0, 0, 0, '0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(eq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_multiport.md
Name: fifo_multiport

Overview:
- Synchronous circular-buffer FIFO that can push up to K entries and pop up to K entries per clock.
- Intended for superscalar front/back-end queues: fetch-to-decode buffer, instruction queue, load/store staging.
- Successor to the single-lane FIFO:
  - adds an asynchronous reset and a synchronous flush;
  - uses all 2**n slots (count-based full/empty, no sacrificed slot);
  - adds occupancy outputs and all-or-nothing multi-entry handshakes.

Parameters:
w, 6, data width per entry in bits
n, 4, address bits; depth D = 2**n entries (n >= 2)
K, 2, lanes per cycle for write and read (1 <= K <= 4, K <= D)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all contents
wr_cnt  in  $clog2(K+1)  number of entries to push this cycle, taken from lanes 0..wr_cnt-1
data_in  in  K*w  lane i = bits [i*w +: w]; lane 0 is oldest
rd_cnt  in  $clog2(K+1)  number of entries to pop this cycle
data_out  out  K*w  lane i = entry at r_addr+i (mod D); lane 0 is head
valid_out  out  K  bit i = (count > i)
count  out  n+1  occupied entries, 0..D
free  out  n+1  D - count
empty  out  1  count == 0
full  out  1  count == D
almost_full  out  1  free < K
wr_err  out  1  one-cycle pulse: write rejected
rd_err  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst_n low, asynchronous):
  - r_addr, w_addr and count go to 0.
  - wr_err and rd_err go to 0.
  - Outputs settle to count=0, free=D, empty=1, full=0, almost_full=0, valid_out=0.
  - The memory array is not reset.
- Deassertion of rst_n is synchronised externally. The first edge after release operates normally.
- Admission is evaluated against registered count and free at the start of the cycle:
  - Write is accepted iff wr_cnt != 0 and wr_cnt <= free.
  - Read is accepted iff rd_cnt != 0 and rd_cnt <= count.
  - Both are all-or-nothing: no partial acceptance.
- An accepted write stores data_in lane i at mem[(w_addr+i) mod D] for i < wr_cnt. Then w_addr += wr_cnt, modulo D with natural n-bit wrap.
- An accepted read advances r_addr += rd_cnt, modulo D.
- Count update: count_next = count + accepted wr_cnt - accepted rd_cnt.
- Simultaneous read and write:
  - Both are judged on pre-cycle state. There is no same-cycle bypass: slots freed by this cycle's read cannot take this cycle's write.
  - When full and both are requested, the read is accepted and the write rejected.
- A rejected request leaves all state unchanged for that side and pulses its error flag high for exactly the next cycle. The flags are registered.
- wr_cnt > K or rd_cnt > K is illegal: it is treated as rejected and flagged.
- flush:
  - Takes priority over same-cycle reads and writes.
  - Next cycle, pointers and count are 0 and error flags are 0.
  - Memory is untouched.
- Read path latency:
  - data_out is combinational from mem at r_addr+i. Write-to-visible latency is 1 cycle.
  - A pushed entry appears at the head the cycle after the push when the FIFO was empty.
  - Lanes with valid_out=0 carry undefined data. Benches must not check them.
- Wrap-around: a lane window crossing index D-1 wraps to 0 correctly for both write and read lanes.
- count, free, empty, full and almost_full are derived combinationally from the registered count.

Decomposition:
- Package fifo_pkg:
  - function clog2 helper;
  - lane-slice localparams (e.g. CNT_W = $clog2(K+1));
  - shared typedef for lane count type.
- One natural sub-module, fifo_ram_mw: a D×w register array with K write ports and K combinational read ports addressed by base+lane offset.
- Control (pointers, count, admission, flags) stays in fifo_multiport.

Test Plan:
- Reset mid-operation:
  - Stimulus: fill 5 entries (w=6, n=4, K=2), then pulse rst_n low between edges.
  - Required: count=0, empty=1, valid_out=0 immediately, without waiting for a clock.
- Dual push/pop ordering:
  - Stimulus: push pairs (1,2),(3,4),(5,6), then pop 2 per cycle.
  - Required: data_out lanes read (1,2),(3,4),(5,6); count goes 6→4→2→0.
- Full and error handling:
  - Stimulus: push 15 entries, then wr_cnt=2.
  - Required: rejected, wr_err=1 for one cycle, count stays 15.
  - Stimulus: then wr_cnt=1.
  - Required: count=16, full=1, almost_full=1.
- Full with simultaneous request:
  - Stimulus: at count=16, rd_cnt=1 together with wr_cnt=1.
  - Required: read accepted, write rejected, count=15, wr_err pulses.
- Wrap-around:
  - Stimulus: advance pointers to 15, push (A,B).
  - Required: entries land in slots 15 and 0; popping 2 yields A then B.
- Underflow and flush:
  - Stimulus: at count=1, rd_cnt=2.
  - Required: rd_err pulses, count stays 1.
  - Stimulus: flush together with wr_cnt=2.
  - Required: count=0 next cycle and no write occurs.
